// File: rtl/iop_gpio_pkg.sv
// iop_gpio_pkg: shared definitions for the IOP-side GPIO peripheral.
//   - Register offsets within the 4 KB peripheral window (byte addresses, word aligned).
//   - IOSIZE transfer-size encodings.
//   - lane_expand(): turns a 4-bit byte-lane strobe into a 32-bit bit mask.
package iop_gpio_pkg;

    localparam logic [11:0] ADDR_DATA      = 12'h000;
    localparam logic [11:0] ADDR_DATAOUT   = 12'h004;
    localparam logic [11:0] ADDR_OUTENSET  = 12'h010;
    localparam logic [11:0] ADDR_OUTENCLR  = 12'h014;
    localparam logic [11:0] ADDR_INTENSET  = 12'h020;
    localparam logic [11:0] ADDR_INTENCLR  = 12'h024;
    localparam logic [11:0] ADDR_INTTYPE   = 12'h028;
    localparam logic [11:0] ADDR_INTPOL    = 12'h02C;
    localparam logic [11:0] ADDR_INTSTATUS = 12'h038;

    typedef enum logic [1:0] {
        SizeByte    = 2'd0,
        SizeHalf    = 2'd1,
        SizeWord    = 2'd2,
        SizeWordAlt = 2'd3
    } iosize_e;

    function automatic logic [31:0] lane_expand(input logic [3:0] strobe);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            mask[8*b +: 8] = {8{strobe[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/iop_gpio_lane_mask.sv
// iop_gpio_lane_mask: combinational byte-lane decoder for IOP writes.
// Ports:
//   i_size     transfer size (byte / halfword / word)
//   i_addr_lo  IOADDR[1:0]
//   o_strobe   4-bit byte-lane strobe
//   o_mask     o_strobe expanded to one bit per data bit
module iop_gpio_lane_mask
    import iop_gpio_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    output logic [3:0]  o_strobe,
    output logic [31:0] o_mask
);

    always_comb begin
        o_strobe = '0;
        unique case (iosize_e'(i_size))
            SizeByte:              o_strobe = 4'b0001 << i_addr_lo;
            SizeHalf:              o_strobe = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            SizeWord, SizeWordAlt: o_strobe = 4'b1111;
        endcase
    end

    assign o_mask = lane_expand(o_strobe);

endmodule

// File: rtl/iop_gpio_port.sv
// iop_gpio_port: GPIO peripheral on the IOP side of the AHB-to-IOP bridge.
// Holds output data / output enable / interrupt configuration registers, samples the
// pins and raises per-pin and combined interrupts.
// Ports:
//   HCLK, HRESETn       clock, synchronous active-low reset
//   IOSEL, IOTRANS      access qualifiers (data phase)
//   IOADDR, IOWRITE     address, direction
//   IOSIZE, IOWDATA     transfer size, write data
//   IORDATA             combinational read data, 0 when no read is active
//   PORTIN              pin inputs (may be asynchronous, see below)
//   PORTOUT, PORTEN     output data and output enable (1 = drive)
//   GPIOINT, COMBINT    per-pin interrupt status and its OR
// Build option: define IOP_GPIO_INPUT_SYNC_EN to insert a 2-flop synchronizer on PORTIN;
// leave it undefined when the pins are already synchronous to HCLK (single sample stage).
module iop_gpio_port
    import iop_gpio_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             IOSEL,
    input  logic [11:0]      IOADDR,
    input  logic             IOWRITE,
    input  logic [1:0]       IOSIZE,
    input  logic             IOTRANS,
    input  logic [31:0]      IOWDATA,
    output logic [31:0]      IORDATA,
    input  logic [WIDTH-1:0] PORTIN,
    output logic [WIDTH-1:0] PORTOUT,
    output logic [WIDTH-1:0] PORTEN,
    output logic [WIDTH-1:0] GPIOINT,
    output logic             COMBINT
);

    logic             w_acc;
    logic             w_wr;
    logic             w_rd;
    logic [11:0]      w_off;
    logic [3:0]       w_strobe;
    logic [31:0]      w_mask32;
    logic [WIDTH-1:0] w_wmask;
    logic [WIDTH-1:0] w_wbits;
    logic [WIDTH-1:0] w_rd_val;

    logic [WIDTH-1:0] r_dataout;
    logic [WIDTH-1:0] r_outen;
    logic [WIDTH-1:0] r_inten;
    logic [WIDTH-1:0] r_inttype;
    logic [WIDTH-1:0] r_intpol;
    logic [WIDTH-1:0] r_intstat;
    logic [WIDTH-1:0] r_pin_s;
    logic [WIDTH-1:0] r_pin_d;

    logic [WIDTH-1:0] w_cond_edge;
    logic [WIDTH-1:0] w_cond_level;
    logic [WIDTH-1:0] w_cond;
    logic [WIDTH-1:0] w_int_set;
    logic [WIDTH-1:0] w_stat_clr;
    logic [WIDTH-1:0] w_intstat_d;
    logic             w_unused_bits;

    assign w_acc = IOSEL & IOTRANS;
    assign w_wr  = w_acc & IOWRITE;
    assign w_rd  = w_acc & ~IOWRITE;
    assign w_off = {IOADDR[11:2], 2'b00};

    iop_gpio_lane_mask u_lane_mask (
        .i_size    (IOSIZE),
        .i_addr_lo (IOADDR[1:0]),
        .o_strobe  (w_strobe),
        .o_mask    (w_mask32)
    );

    // Only the lanes being written contribute; bits above WIDTH are simply dropped.
    assign w_wmask = w_mask32[WIDTH-1:0];
    assign w_wbits = IOWDATA[WIDTH-1:0] & w_wmask;

    // Write data above WIDTH and the raw strobe are intentionally not consumed.
    assign w_unused_bits = ^{IOWDATA, w_mask32, w_strobe};

    // ---------------------------------------------------------------- pin sampling
`ifdef IOP_GPIO_INPUT_SYNC_EN
    logic [WIDTH-1:0] r_pin_meta;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_pin_meta <= '0;
            r_pin_s    <= '0;
            r_pin_d    <= '0;
        end else begin
            r_pin_meta <= PORTIN;
            r_pin_s    <= r_pin_meta;
            r_pin_d    <= r_pin_s;
        end
    end
`else
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_pin_s <= '0;
            r_pin_d <= '0;
        end else begin
            r_pin_s <= PORTIN;
            r_pin_d <= r_pin_s;
        end
    end
`endif

    // ---------------------------------------------------------------- interrupt logic
    assign w_cond_edge  = (r_intpol & r_pin_s & ~r_pin_d) | (~r_intpol & ~r_pin_s & r_pin_d);
    assign w_cond_level = ~(r_pin_s ^ r_intpol);
    assign w_cond       = (r_inttype & w_cond_edge) | (~r_inttype & w_cond_level);
    assign w_int_set    = r_inten & w_cond;
    assign w_stat_clr   = (w_wr && (w_off == ADDR_INTSTATUS)) ? w_wbits : '0;

    // Edge bits are sticky with set taking priority over a same-cycle clear; level bits
    // simply track the enabled condition, so a clear cannot outlast the condition.
    assign w_intstat_d  = (r_inttype & ((r_intstat & ~w_stat_clr) | w_int_set))
                        | (~r_inttype & w_int_set);

    // ---------------------------------------------------------------- registers
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_dataout <= '0;
            r_outen   <= '0;
            r_inten   <= '0;
            r_inttype <= '0;
            r_intpol  <= '0;
            r_intstat <= '0;
        end else begin
            r_intstat <= w_intstat_d;
            if (w_wr) begin
                case (w_off)
                    ADDR_DATAOUT:  r_dataout <= (r_dataout & ~w_wmask) | w_wbits;
                    ADDR_OUTENSET: r_outen   <= r_outen | w_wbits;
                    ADDR_OUTENCLR: r_outen   <= r_outen & ~w_wbits;
                    ADDR_INTENSET: r_inten   <= r_inten | w_wbits;
                    ADDR_INTENCLR: r_inten   <= r_inten & ~w_wbits;
                    ADDR_INTTYPE:  r_inttype <= (r_inttype & ~w_wmask) | w_wbits;
                    ADDR_INTPOL:   r_intpol  <= (r_intpol & ~w_wmask) | w_wbits;
                    default: ;
                endcase
            end
        end
    end

    // ---------------------------------------------------------------- read mux
    always_comb begin
        w_rd_val = '0;
        if (w_rd) begin
            case (w_off)
                ADDR_DATA:                     w_rd_val = r_pin_s;
                ADDR_DATAOUT:                  w_rd_val = r_dataout;
                ADDR_OUTENSET, ADDR_OUTENCLR:  w_rd_val = r_outen;
                ADDR_INTENSET, ADDR_INTENCLR:  w_rd_val = r_inten;
                ADDR_INTTYPE:                  w_rd_val = r_inttype;
                ADDR_INTPOL:                   w_rd_val = r_intpol;
                ADDR_INTSTATUS:                w_rd_val = r_intstat;
                default:                       w_rd_val = '0;
            endcase
        end
        IORDATA              = '0;
        IORDATA[WIDTH-1:0]   = w_rd_val;
    end

    assign PORTOUT = r_dataout;
    assign PORTEN  = r_outen;
    assign GPIOINT = r_intstat;
    assign COMBINT = |r_intstat;

endmodule

// File: tb/tb_iop_gpio_port.sv
module tb_iop_gpio_port;

    localparam int unsigned WIDTH = 16;
`ifdef IOP_GPIO_INPUT_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic             HCLK = 1'b0;
    logic             HRESETn;
    logic             IOSEL;
    logic [11:0]      IOADDR;
    logic             IOWRITE;
    logic [1:0]       IOSIZE;
    logic             IOTRANS;
    logic [31:0]      IOWDATA;
    logic [31:0]      IORDATA;
    logic [WIDTH-1:0] PORTIN;
    logic [WIDTH-1:0] PORTOUT;
    logic [WIDTH-1:0] PORTEN;
    logic [WIDTH-1:0] GPIOINT;
    logic             COMBINT;

    always #5 HCLK = ~HCLK;

    iop_gpio_port #(.WIDTH(WIDTH)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .IOSEL   (IOSEL),
        .IOADDR  (IOADDR),
        .IOWRITE (IOWRITE),
        .IOSIZE  (IOSIZE),
        .IOTRANS (IOTRANS),
        .IOWDATA (IOWDATA),
        .IORDATA (IORDATA),
        .PORTIN  (PORTIN),
        .PORTOUT (PORTOUT),
        .PORTEN  (PORTEN),
        .GPIOINT (GPIOINT),
        .COMBINT (COMBINT)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference model
    // Register contents as the programmer sees them, plus a history of pin samples
    // (index 0 = value captured at the most recent edge).
    logic [WIDTH-1:0] m_dataout, m_outen, m_inten, m_type, m_pol, m_stat;
    logic [WIDTH-1:0] m_pins[$];

    function automatic bit lane_sel(input logic [1:0] sz, input logic [1:0] a, input int b);
        if (sz == 2'd0) return (b == int'(a));
        if (sz == 2'd1) return a[1] ? (b >= 2) : (b < 2);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [11:0] a);
        logic [31:0] r;
        r = '0;
        case ({a[11:2], 2'b00})
            12'h000:          r[WIDTH-1:0] = m_pins[SYNC_LAT-1];
            12'h004:          r[WIDTH-1:0] = m_dataout;
            12'h010, 12'h014: r[WIDTH-1:0] = m_outen;
            12'h020, 12'h024: r[WIDTH-1:0] = m_inten;
            12'h028:          r[WIDTH-1:0] = m_type;
            12'h02C:          r[WIDTH-1:0] = m_pol;
            12'h038:          r[WIDTH-1:0] = m_stat;
            default:          r = '0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [31:0]      m32;
        logic [WIDTH-1:0] keep, val, clr, nxt;
        logic [11:0]      off;
        bit               wr, s, d, cond;
        if (!HRESETn) begin
            {m_dataout, m_outen, m_inten, m_type, m_pol, m_stat} = '0;
            m_pins.delete();
            for (int i = 0; i <= SYNC_LAT; i++) m_pins.push_back('0);
            return;
        end
        m32 = '0;
        for (int b = 0; b < 4; b++) if (lane_sel(IOSIZE, IOADDR[1:0], b)) m32[8*b +: 8] = 8'hFF;
        keep = m32[WIDTH-1:0];
        val  = IOWDATA[WIDTH-1:0] & keep;
        off  = {IOADDR[11:2], 2'b00};
        wr   = IOSEL && IOTRANS && IOWRITE;
        clr  = (wr && off == 12'h038) ? val : '0;
        for (int i = 0; i < WIDTH; i++) begin
            s = m_pins[SYNC_LAT-1][i];
            d = m_pins[SYNC_LAT][i];
            if (m_type[i]) cond = m_pol[i] ? (s && !d) : (!s && d);
            else           cond = (s == m_pol[i]);
            if (m_type[i]) nxt[i] = (m_inten[i] && cond) || (m_stat[i] && !clr[i]);
            else           nxt[i] = m_inten[i] && cond;
        end
        m_stat = nxt;
        if (wr) begin
            case (off)
                12'h004: m_dataout = (m_dataout & ~keep) | val;
                12'h010: m_outen   = m_outen | val;
                12'h014: m_outen   = m_outen & ~val;
                12'h020: m_inten   = m_inten | val;
                12'h024: m_inten   = m_inten & ~val;
                12'h028: m_type    = (m_type & ~keep) | val;
                12'h02C: m_pol     = (m_pol & ~keep) | val;
                default: ;
            endcase
        end
        m_pins.push_front(PORTIN);
        void'(m_pins.pop_back());
    endtask

    initial forever begin
        @(posedge HCLK);
        model_step();
    end

    // ------------------------------------------------------------ bus tasks
    // All tasks start and end just after a falling edge.
    task automatic idle();
        IOSEL   = 1'b0;
        IOTRANS = 1'b0;
        IOWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [1:0] sz, input logic [31:0] d);
        IOSEL = 1'b1; IOTRANS = 1'b1; IOWRITE = 1'b1;
        IOADDR = a; IOSIZE = sz; IOWDATA = d;
        @(negedge HCLK);
        idle();
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        IOSEL = 1'b1; IOTRANS = 1'b1; IOWRITE = 1'b0;
        IOADDR = a; IOSIZE = 2'd2;
        #1 d = IORDATA;
        idle();
        @(negedge HCLK);
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp;   // write: {PORTEN, PORTOUT}; read: IORDATA
    } vec_t;

    vec_t        vecs[19];
    logic [11:0] offs[12];
    logic [31:0] rd;

    initial begin
        offs = '{12'h000, 12'h004, 12'h010, 12'h014, 12'h020, 12'h024,
                 12'h028, 12'h02C, 12'h038, 12'h03C, 12'h030, 12'hFFC};
        vecs = '{
            '{1'b1, 12'h004, 2'd2, 32'h0000A5A5, 32'h0000_A5A5},
            '{1'b1, 12'h005, 2'd0, 32'h3C3C3C3C, 32'h0000_3CA5},
            '{1'b0, 12'h004, 2'd2, 32'h0,        32'h0000_3CA5},
            '{1'b1, 12'h010, 2'd2, 32'h000000FF, 32'h00FF_3CA5},
            '{1'b1, 12'h014, 2'd2, 32'h0000000F, 32'h00F0_3CA5},
            '{1'b0, 12'h010, 2'd2, 32'h0,        32'h0000_00F0},
            '{1'b0, 12'h014, 2'd2, 32'h0,        32'h0000_00F0},
            '{1'b1, 12'h006, 2'd1, 32'hBEEF0000, 32'h00F0_3CA5},
            '{1'b1, 12'h004, 2'd1, 32'h12345678, 32'h00F0_5678},
            '{1'b1, 12'h004, 2'd2, 32'hFFFFFFFF, 32'h00F0_FFFF},
            '{1'b0, 12'h004, 2'd2, 32'h0,        32'h0000_FFFF},
            '{1'b1, 12'h000, 2'd2, 32'h00001234, 32'h00F0_FFFF},
            '{1'b1, 12'h03C, 2'd2, 32'hFFFFFFFF, 32'h00F0_FFFF},
            '{1'b0, 12'h03C, 2'd2, 32'h0,        32'h0000_0000},
            '{1'b1, 12'h007, 2'd0, 32'h11111111, 32'h00F0_FFFF},
            '{1'b1, 12'h007, 2'd3, 32'h000000AA, 32'h00F0_00AA},
            '{1'b1, 12'h015, 2'd0, 32'h0000FF00, 32'h00F0_00AA},
            '{1'b1, 12'h014, 2'd0, 32'h000000F0, 32'h0000_00AA},
            '{1'b0, 12'h000, 2'd2, 32'h0,        32'h0000_0000}
        };

        HRESETn = 1'b0;
        idle();
        IOADDR = '0; IOSIZE = '0; IOWDATA = '0; PORTIN = '0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        // Reset state
        check("reset_portout", 32'(PORTOUT), 32'h0);
        check("reset_porten",  32'(PORTEN),  32'h0);
        check("reset_gpioint", 32'(GPIOINT), 32'h0);
        check("reset_combint", 32'(COMBINT), 32'h0);
        foreach (offs[i]) begin
            bus_read(offs[i], rd);
            check($sformatf("reset_rd_%03h", offs[i]), rd, 32'h0);
        end

        // Table-driven register accesses
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].size, vecs[i].wdata);
                check($sformatf("vec%0d_en_out", i), {PORTEN, PORTOUT}, vecs[i].exp);
            end else begin
                bus_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp);
            end
        end

        // Rising-edge interrupt on bit 3
        bus_write(12'h028, 2'd2, 32'h8);
        bus_write(12'h02C, 2'd2, 32'h8);
        bus_write(12'h020, 2'd2, 32'h8);
        check("edge_idle", 32'(GPIOINT), 32'h0);
        PORTIN = 16'h0008;
        repeat (SYNC_LAT) @(negedge HCLK);
        check("edge_early", 32'(GPIOINT), 32'h0);
        @(negedge HCLK);
        check("edge_set", 32'(GPIOINT), 32'h8);
        check("edge_combint", 32'(COMBINT), 32'h1);
        repeat (2) @(negedge HCLK);
        check("edge_sticky", 32'(GPIOINT), 32'h8);
        bus_write(12'h038, 2'd2, 32'h8);
        check("edge_w1c", 32'(GPIOINT), 32'h0);
        check("edge_w1c_combint", 32'(COMBINT), 32'h0);

        // Falling edge must not set; then set and clear land on the same edge
        PORTIN = 16'h0000;
        repeat (SYNC_LAT + 2) @(negedge HCLK);
        check("edge_fall_ignored", 32'(GPIOINT), 32'h0);
        PORTIN = 16'h0008;
        repeat (SYNC_LAT) @(negedge HCLK);
        bus_write(12'h038, 2'd2, 32'h8);
        check("edge_set_wins", 32'(GPIOINT), 32'h8);
        bus_write(12'h038, 2'd2, 32'h8);
        check("edge_clear_again", 32'(GPIOINT), 32'h0);

        // Level, active-low interrupt on bit 0
        PORTIN = 16'h0000;
        bus_write(12'h024, 2'd2, 32'h8);
        bus_write(12'h028, 2'd2, 32'h0);
        bus_write(12'h02C, 2'd2, 32'h0);
        bus_write(12'h020, 2'd2, 32'h1);
        check("level_latency", 32'(GPIOINT), 32'h0);
        @(negedge HCLK);
        check("level_set", 32'(GPIOINT), 32'h1);
        bus_write(12'h038, 2'd2, 32'h1);
        check("level_w1c_held", 32'(GPIOINT), 32'h1);
        @(negedge HCLK);
        check("level_w1c_held2", 32'(GPIOINT), 32'h1);
        PORTIN = 16'h0001;
        repeat (SYNC_LAT) @(negedge HCLK);
        check("level_release_early", 32'(GPIOINT), 32'h1);
        @(negedge HCLK);
        check("level_release", 32'(GPIOINT), 32'h0);
        PORTIN = 16'h0000;
        repeat (SYNC_LAT + 1) @(negedge HCLK);
        check("level_reassert", 32'(GPIOINT), 32'h1);
        bus_write(12'h024, 2'd2, 32'h1);
        check("level_inten_off_lat", 32'(GPIOINT), 32'h1);
        @(negedge HCLK);
        check("level_inten_off", 32'(GPIOINT), 32'h0);

        // Reset during an active write
        check("pre_reset_portout", 32'(PORTOUT), 32'h00AA);
        IOSEL = 1'b1; IOTRANS = 1'b1; IOWRITE = 1'b1;
        IOADDR = 12'h004; IOSIZE = 2'd2; IOWDATA = 32'h5555;
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        idle();
        check("rst_mid_portout", 32'(PORTOUT), 32'h0);
        check("rst_mid_porten",  32'(PORTEN),  32'h0);
        bus_read(12'h004, rd);
        check("rst_mid_rd", rd, 32'h0);

        // Randomized traffic against the model
        for (int it = 0; it < 800; it++) begin
            PORTIN  = WIDTH'($urandom);
            HRESETn = ($urandom_range(0, 127) != 0);
            IOSEL   = ($urandom_range(0, 7) != 0);
            IOTRANS = ($urandom_range(0, 7) != 0);
            IOWRITE = 1'($urandom_range(0, 1));
            IOADDR  = offs[$urandom_range(0, 11)] | 12'($urandom_range(0, 3));
            IOSIZE  = 2'($urandom_range(0, 3));
            IOWDATA = $urandom;
            #1;
            check("rand_rdata", IORDATA,
                  (IOSEL && IOTRANS && !IOWRITE) ? exp_read(IOADDR) : 32'h0);
            @(negedge HCLK);
            check("rand_portout", 32'(PORTOUT), 32'(m_dataout));
            check("rand_porten",  32'(PORTEN),  32'(m_outen));
            check("rand_gpioint", 32'(GPIOINT), 32'(m_stat));
            check("rand_combint", 32'(COMBINT), 32'(m_stat != '0));
        end
        HRESETn = 1'b1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
